// File: rtl/voice_allocator.sv
// voice_allocator: polyphonic MIDI voice allocator.
// Each accepted note event triggers a full scan of the voice table in external
// RAM (asynchronous read), followed by a single masked write to the chosen voice.
// Entry layout: bit 14 active, bits 13:7 note, bits 6:0 velocity, upper bits 0.
// Optional feature macro: VOICE_STEAL_EN -- when defined, a note-on that finds
// neither a matching nor a free voice steals one using a round-robin pointer.
// When it is not defined, such a note-on is dropped.
module voice_allocator #(
    parameter int VOICE_BITS = 3,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ev_valid,
    output logic                  ev_ready,
    input  logic                  ev_on,
    input  logic [6:0]            ev_note,
    input  logic [6:0]            ev_vel,
    output logic [VOICE_BITS-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic [DATA_WIDTH-1:0] ram_mask,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  done,
    output logic [VOICE_BITS-1:0] voice_idx,
    output logic                  dropped
);

    if (DATA_WIDTH < 15) begin : g_width_check
        $error("voice_allocator: DATA_WIDTH must be at least 15");
    end

    localparam int                    ACT_BIT  = 14;
    localparam logic [VOICE_BITS-1:0] LAST_IDX = '1;
    localparam logic [VOICE_BITS-1:0] IDX_ONE  = VOICE_BITS'(1);

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        SCAN  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [VOICE_BITS-1:0] idx;
    logic                  off_q;
    logic [6:0]            note_q;
    logic [6:0]            vel_q;
    logic                  match_vld;
    logic [VOICE_BITS-1:0] match_idx;
    logic                  free_vld;
    logic [VOICE_BITS-1:0] free_idx;
    logic [VOICE_BITS-1:0] vidx_q;

    logic                  accept;
    logic                  dout_active;
    logic [6:0]            dout_note;
    logic                  tgt_vld;
    logic [VOICE_BITS-1:0] tgt_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] wr_mask;
    logic                  unused_dout;

`ifdef VOICE_STEAL_EN
    logic [VOICE_BITS-1:0] steal_ptr;
    logic                  steal_use;
`endif

    assign accept      = (state == IDLE) && ev_valid;
    assign dout_active = ram_dout[ACT_BIT];
    assign dout_note   = ram_dout[13:7];
    // Velocity and padding bits of the read data are never inspected.
    assign unused_dout = ^ram_dout;

    // State register; reset always restarts table initialisation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Index counter, event latch, scan results and last-written voice.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx       <= '0;
            off_q     <= 1'b0;
            note_q    <= '0;
            vel_q     <= '0;
            match_vld <= 1'b0;
            match_idx <= '0;
            free_vld  <= 1'b0;
            free_idx  <= '0;
            vidx_q    <= '0;
        end else begin
            case (state)
                INIT: begin
                    idx <= idx + IDX_ONE;
                end
                IDLE: begin
                    idx <= '0;
                    if (accept) begin
                        // A note-on with zero velocity behaves as a note-off.
                        off_q     <= !ev_on || (ev_vel == 7'd0);
                        note_q    <= ev_note;
                        vel_q     <= ev_vel;
                        match_vld <= 1'b0;
                        free_vld  <= 1'b0;
                    end
                end
                SCAN: begin
                    idx <= idx + IDX_ONE;
                    if (dout_active && (dout_note == note_q) && !match_vld) begin
                        match_vld <= 1'b1;
                        match_idx <= idx;
                    end
                    if (!dout_active && !free_vld) begin
                        free_vld <= 1'b1;
                        free_idx <= idx;
                    end
                end
                WRITE: begin
                    if (tgt_vld) begin
                        vidx_q <= tgt_idx;
                    end
                end
                default: begin
                    idx <= '0;
                end
            endcase
        end
    end

`ifdef VOICE_STEAL_EN
    // Round-robin steal pointer, advanced only when a voice is actually stolen.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            steal_ptr <= '0;
        end else if (state == WRITE && steal_use) begin
            steal_ptr <= steal_ptr + IDX_ONE;
        end
    end
`endif

    // Target selection: match first, then lowest free voice, then steal if enabled.
    always_comb begin
        tgt_vld = 1'b0;
        tgt_idx = '0;
`ifdef VOICE_STEAL_EN
        steal_use = 1'b0;
`endif
        if (off_q) begin
            tgt_vld = match_vld;
            tgt_idx = match_idx;
        end else if (match_vld) begin
            tgt_vld = 1'b1;
            tgt_idx = match_idx;
        end else if (free_vld) begin
            tgt_vld = 1'b1;
            tgt_idx = free_idx;
        end
`ifdef VOICE_STEAL_EN
        else begin
            tgt_vld   = 1'b1;
            tgt_idx   = steal_ptr;
            steal_use = 1'b1;
        end
`endif
    end

    // Write payload: note-off clears only the active bit so note/velocity survive.
    always_comb begin
        wr_data = '0;
        wr_mask = '0;
        if (off_q) begin
            wr_mask[ACT_BIT] = 1'b1;
        end else begin
            wr_data[ACT_BIT] = 1'b1;
            wr_data[13:7]    = note_q;
            wr_data[6:0]     = vel_q;
            wr_mask          = '1;
        end
    end

    // Next-state and outputs; every output is held at zero while rst_n is low.
    always_comb begin
        state_nxt = state;
        ev_ready  = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_din   = '0;
        ram_mask  = '0;
        done      = 1'b0;
        dropped   = 1'b0;
        voice_idx = '0;
        if (rst_n) begin
            voice_idx = vidx_q;
            case (state)
                INIT: begin
                    ram_we   = 1'b1;
                    ram_addr = idx;
                    ram_mask = '1;
                    if (idx == LAST_IDX) begin
                        state_nxt = IDLE;
                    end
                end
                IDLE: begin
                    ev_ready = 1'b1;
                    if (ev_valid) begin
                        state_nxt = SCAN;
                    end
                end
                SCAN: begin
                    ram_addr = idx;
                    if (idx == LAST_IDX) begin
                        state_nxt = WRITE;
                    end
                end
                WRITE: begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                    if (tgt_vld) begin
                        ram_we    = 1'b1;
                        ram_addr  = tgt_idx;
                        ram_din   = wr_data;
                        ram_mask  = wr_mask;
                        voice_idx = tgt_idx;
                    end else begin
                        dropped = 1'b1;
                    end
                end
                default: begin
                    state_nxt = INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Testbench for voice_allocator: behavioural voice-table RAM, vector table of
// note events with expected writes, and a scoreboard queue popped on done.
module tb_voice_allocator;

    localparam int VB = 3;
    localparam int DW = 16;
    localparam int NV = 8;

    logic          clk;
    logic          rst_n;
    logic          ev_valid;
    logic          ev_ready;
    logic          ev_on;
    logic [6:0]    ev_note;
    logic [6:0]    ev_vel;
    logic [VB-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_mask;
    logic          ram_we;
    logic [DW-1:0] ram_dout;
    logic          done;
    logic [VB-1:0] voice_idx;
    logic          dropped;

    logic [DW-1:0] mem [NV];

    typedef struct {
        bit        on;
        bit [6:0]  note;
        bit [6:0]  vel;
        bit        we;
        bit [2:0]  addr;
        bit [15:0] din;
        bit [15:0] mask;
        bit        drop;
    } vec_t;

    vec_t          vecs[$];
    vec_t          exp_q[$];
    int            total = 0;
    int            bad = 0;
    logic [VB-1:0] exp_vidx = '0;

    voice_allocator #(
        .VOICE_BITS(VB),
        .DATA_WIDTH(DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_on    (ev_on),
        .ev_note  (ev_note),
        .ev_vel   (ev_vel),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_mask (ram_mask),
        .ram_we   (ram_we),
        .ram_dout (ram_dout),
        .done     (done),
        .voice_idx(voice_idx),
        .dropped  (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Voice-table RAM: asynchronous read, per-bit masked synchronous write.
    assign ram_dout = mem[ram_addr];
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= (mem[ram_addr] & ~ram_mask) | (ram_din & ram_mask);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic bit [15:0] ent(input bit [6:0] n, input bit [6:0] v);
        return {2'b01, n, v};
    endfunction

    task automatic add(input bit on, input bit [6:0] note, input bit [6:0] vel,
                       input bit we, input bit [2:0] addr, input bit [15:0] din,
                       input bit [15:0] mask, input bit drop);
        vec_t v;
        v.on = on; v.note = note; v.vel = vel; v.we = we;
        v.addr = addr; v.din = din; v.mask = mask; v.drop = drop;
        vecs.push_back(v);
    endtask

    task automatic rst_outputs(input string nm);
        chk(nm, {22'd0, ram_we, ev_ready, done, dropped, ram_addr, ram_din, ram_mask, voice_idx}, 64'd0);
    endtask

    // Release reset and follow the table clear, then expect the allocator ready.
    task automatic init_seq();
        @(negedge clk);
        rst_n = 1'b1;
        exp_vidx = '0;
        for (int i = 0; i < NV; i++) begin
            #1;
            chk("init_we", 64'(ram_we), 64'(1'b1));
            chk("init_addr", 64'(ram_addr), 64'(i));
            chk("init_din", 64'(ram_din), 64'd0);
            chk("init_mask", 64'(ram_mask), 64'(16'hFFFF));
            chk("init_busy", 64'({ev_ready, done, dropped}), 64'd0);
            @(negedge clk);
        end
        #1;
        chk("init_ready", 64'(ev_ready), 64'(1'b1));
        chk("init_vidx", 64'(voice_idx), 64'd0);
    endtask

    // Drive one event, scramble the held inputs during the scan, compare on done.
    task automatic send(input vec_t v);
        bit   got_ready = 1'b0;
        bit   seen = 1'b0;
        bit   quiet = 1'b1;
        vec_t e;
        for (int w = 0; w < 40; w++) begin
            @(negedge clk);
            if (ev_ready) begin
                got_ready = 1'b1;
                break;
            end
        end
        chk("ready_wait", 64'(got_ready), 64'(1'b1));
        if (!got_ready) return;
        ev_valid = 1'b1;
        ev_on    = v.on;
        ev_note  = v.note;
        ev_vel   = v.vel;
        exp_q.push_back(v);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) begin
                ev_on   = ~v.on;
                ev_note = v.note ^ 7'h55;
                ev_vel  = v.vel ^ 7'h2A;
            end
            if (done) begin
                ev_valid = 1'b0;
                seen = 1'b1;
                e = exp_q.pop_front();
                chk("latency", 64'(c), 64'(NV + 1));
                chk("write_we", 64'(ram_we), 64'(e.we));
                chk("dropped", 64'(dropped), 64'(e.drop));
                if (e.we) begin
                    exp_vidx = e.addr;
                    chk("write_addr", 64'(ram_addr), 64'(e.addr));
                    chk("write_din", 64'(ram_din), 64'(e.din));
                    chk("write_mask", 64'(ram_mask), 64'(e.mask));
                end
                chk("voice_idx", 64'(voice_idx), 64'(exp_vidx));
                break;
            end
            if (ram_we || ev_ready || dropped) quiet = 1'b0;
        end
        chk("done_seen", 64'(seen), 64'(1'b1));
        if (!seen) begin
            ev_valid = 1'b0;
            e = exp_q.pop_front();
            return;
        end
        chk("scan_quiet", 64'(quiet), 64'(1'b1));
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'd0);
        chk("ready_back", 64'(ev_ready), 64'(1'b1));
    endtask

    initial begin
        rst_n    = 1'b0;
        ev_valid = 1'b0;
        ev_on    = 1'b0;
        ev_note  = '0;
        ev_vel   = '0;

        // Phase 1 vectors: retrigger, note-off, no-match drops, fill, overflow.
        add(1'b1, 7'd60, 7'd100, 1'b1, 3'd0, 16'h5E64, 16'hFFFF, 1'b0);
        add(1'b1, 7'd60, 7'd50,  1'b1, 3'd0, 16'h5E32, 16'hFFFF, 1'b0);
        add(1'b0, 7'd60, 7'd33,  1'b1, 3'd0, 16'h0000, 16'h4000, 1'b0);
        add(1'b0, 7'd99, 7'd10,  1'b0, 3'd0, 16'h0000, 16'h0000, 1'b1);
        add(1'b1, 7'd61, 7'd20,  1'b1, 3'd0, 16'h5E94, 16'hFFFF, 1'b0);
        add(1'b1, 7'd61, 7'd0,   1'b1, 3'd0, 16'h0000, 16'h4000, 1'b0);
        add(1'b1, 7'd61, 7'd0,   1'b0, 3'd0, 16'h0000, 16'h0000, 1'b1);
        for (int i = 0; i < NV; i++)
            add(1'b1, 7'(60 + i), 7'h40, 1'b1, 3'(i), ent(7'(60 + i), 7'h40), 16'hFFFF, 1'b0);
`ifdef VOICE_STEAL_EN
        add(1'b1, 7'd70, 7'd1, 1'b1, 3'd0, 16'h6301, 16'hFFFF, 1'b0);
        add(1'b1, 7'd71, 7'd1, 1'b1, 3'd1, 16'h6381, 16'hFFFF, 1'b0);
`else
        add(1'b1, 7'd70, 7'd1, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b1);
        add(1'b1, 7'd71, 7'd1, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b1);
`endif
        add(1'b1, 7'd65, 7'd9,  1'b1, 3'd5, 16'h6089, 16'hFFFF, 1'b0);
        add(1'b0, 7'd66, 7'd0,  1'b1, 3'd6, 16'h0000, 16'h4000, 1'b0);

        repeat (3) begin
            @(negedge clk);
            rst_outputs("reset_outputs");
        end
        init_seq();

        for (int i = 0; i < vecs.size(); i++) send(vecs[i]);

        // Reset in the middle of a scan: pending event must vanish.
        @(negedge clk);
        chk("mid_ready", 64'(ev_ready), 64'(1'b1));
        ev_valid = 1'b1;
        ev_on    = 1'b1;
        ev_note  = 7'd62;
        ev_vel   = 7'd5;
        @(negedge clk);
        ev_valid = 1'b0;
        chk("mid_accepted", 64'(ev_ready), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_outputs("mid_reset_now");
        @(negedge clk);
        rst_outputs("mid_reset_hold1");
        @(negedge clk);
        rst_outputs("mid_reset_hold2");
        init_seq();
        chk("scoreboard_empty_mid", 64'(exp_q.size()), 64'd0);

        // Phase 2: table was cleared, steal pointer restarts at voice 0.
        vecs.delete();
        add(1'b1, 7'd62, 7'd5, 1'b1, 3'd0, 16'h5F05, 16'hFFFF, 1'b0);
        for (int i = 1; i < NV; i++)
            add(1'b1, 7'(62 + i), 7'h40, 1'b1, 3'(i), ent(7'(62 + i), 7'h40), 16'hFFFF, 1'b0);
`ifdef VOICE_STEAL_EN
        add(1'b1, 7'd72, 7'd2, 1'b1, 3'd0, 16'h6402, 16'hFFFF, 1'b0);
`else
        add(1'b1, 7'd72, 7'd2, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b1);
`endif
        for (int i = 0; i < vecs.size(); i++) send(vecs[i]);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 SHALL have parameter VOICE_BITS, default 3, log2 of the voice count N (N = 8 by default); it drives the voice-table RAM addr_width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, the voice-entry width; it SHALL be at least 15.
REQ-003 clk  in  1  sole clock; all state changes on the rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 ev_valid  in  1  MIDI note event present.
REQ-006 ev_ready  out  1  allocator can accept an event.
REQ-007 ev_on  in  1  1 = note-on, 0 = note-off.
REQ-008 ev_note  in  7  MIDI note number.
REQ-009 ev_vel  in  7  MIDI velocity.
REQ-010 ram_addr  out  VOICE_BITS  voice-table address.
REQ-011 ram_din  out  DATA_WIDTH  write data.
REQ-012 ram_mask  out  DATA_WIDTH  per-bit write mask.
REQ-013 ram_we  out  1  write enable.
REQ-014 ram_dout  in  DATA_WIDTH  asynchronous read data for ram_addr.
REQ-015 done  out  1  one-cycle pulse when an event completes.
REQ-016 voice_idx  out  VOICE_BITS  voice written by the last completed event.
REQ-017 dropped  out  1  one-cycle pulse when an event causes no write.

Function
REQ-018 Entry layout SHALL be: bit14 active, bits13:7 note, bits6:0 velocity; bits above 14 SHALL be written as 0.
REQ-019 The FSM SHALL have four states: INIT, IDLE, SCAN, WRITE.
REQ-020 In INIT, the block SHALL write all-zero entries to addresses 0..N-1, one per cycle, with full mask, and then enter IDLE.
REQ-021 ev_ready SHALL be 1 only in IDLE.
REQ-022 An event SHALL be accepted on a cycle with ev_valid=1 and ev_ready=1, and its fields SHALL be latched.
REQ-023 Once accepted, the block SHALL enter SCAN with ram_addr=0.
REQ-024 SCAN SHALL read index i per cycle for i=0..N-1 with ram_we=0, always performing the full scan.
REQ-025 During SCAN, the block SHALL record the lowest active index whose note equals ev_note ("match") and the lowest inactive index ("free").
REQ-026 After index N-1, the block SHALL enter WRITE for exactly one cycle.
REQ-027 Latency from accept to the WRITE cycle SHALL be N+1 cycles.
REQ-028 A note-on with ev_vel=0 SHALL be treated as a note-off.
REQ-029 Note-on target selection SHALL be: match if present, else free, else the steal target per REQ-041/REQ-042.
REQ-030 A note-on write SHALL use ram_din={active=1, note, vel} with the full mask.
REQ-031 Note-off: if a match is present, the block SHALL write ram_din=0 with ram_mask = bit14 only, preserving note and velocity for release.
REQ-032 Note-off with no match SHALL perform no write and SHALL pulse dropped.
REQ-033 In the WRITE cycle: ram_we=1 if a target exists, done=1, and voice_idx SHALL update to the target; the block SHALL return to IDLE on the next cycle.
REQ-034 dropped and done SHALL pulse in the same WRITE cycle when no write occurs.
REQ-035 ev_valid is ignored outside IDLE, and the held event fields are not resampled.

Reset
REQ-036 rst_n=0 at any edge, including mid-SCAN or mid-INIT, SHALL force INIT with index 0.
REQ-037 During reset: ev_ready=0, ram_we=0, done=0, dropped=0, voice_idx=0, ram_addr=0, ram_din=0, ram_mask=0, steal pointer=0.
REQ-038 An event in progress at reset SHALL be discarded.
REQ-039 The first INIT write SHALL occur on the first cycle with rst_n=1.
REQ-040 IDLE SHALL be reached N cycles after reset release.

Configuration
REQ-041 With macro VOICE_STEAL_EN defined: a note-on with no match and no free voice SHALL overwrite the voice at a round-robin steal pointer, which then increments modulo N.
REQ-042 With VOICE_STEAL_EN undefined: a note-on with no match and no free voice SHALL perform no write and SHALL pulse dropped, and no steal pointer logic SHALL exist.

Verification
REQ-043 Reset release -> ram_we=1 for 8 cycles at addr 0..7 with din=0; ev_ready rises on cycle 9.
REQ-044 Note-on note 60 vel 100 into an empty table -> WRITE 9 cycles after accept: addr 0, din=0x5E64, done=1, voice_idx=0.
REQ-045 Note-on 60 again with vel 50 -> retrigger voice 0, din=0x5E32; then note-off 60 -> addr 0, mask=0x4000, din=0.
REQ-046 Eight note-ons 60..67, then note-on 70 -> with VOICE_STEAL_EN: voice 0 written, then voice 1 on the next overflow; without it: dropped=1 and no ram_we.
REQ-047 Note-off 99 with no match -> dropped=1, done=1, ram_we=0; note-on 61 with vel 0 -> treated as a note-off.
REQ-048 rst_n pulsed low mid-SCAN -> no WRITE of the pending event; INIT restarts at addr 0.
